// File: rtl/rr_lock_arb_pkg.sv
// rtl/rr_lock_arb_pkg.sv - shared types, defaults and helpers for rr_lock_arbiter
package rr_lock_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_SIZE     = 4;
    localparam int DEF_HOLD_CYC = 16;
    localparam int MAX_SIZE     = 64;

    // Binary index of a one-hot vector; callers zero-extend narrower vectors.
    function automatic logic [31:0] onehot_to_idx(input logic [MAX_SIZE-1:0] vec);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            if (vec[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick_msb.sv
// rtl/prio_pick_msb.sv - combinational one-hot pick of the highest set bit
module prio_pick_msb #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] vec,
    output logic [SIZE-1:0] onehot
);

    // Ascending scan: the last (highest) set bit overwrites any lower pick.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - registered round-robin arbiter with grant locking
// Optional forced release after HOLD_CYC busy cycles: RR_LOCK_ARB_HOLD_TIMEOUT_EN
module rr_lock_arbiter
    import rr_lock_arb_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int ID_W     = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] req,
    input  logic            ready,
    input  logic            last,
    output logic [SIZE-1:0] gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            timeout
);

    if (SIZE < 2 || SIZE > MAX_SIZE || HOLD_CYC < 1) begin : g_param_check
        $error("rr_lock_arbiter: unsupported SIZE or HOLD_CYC");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [SIZE-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            valid_q, valid_d;

    logic [SIZE-1:0] mask, masked, pick_m, pick_r, winner;
    logic [ID_W-1:0] win_idx;
    logic            rel_beat;
    logic            hold_hit;

    // Bits strictly below ptr get first chance, so the last winner ranks lowest.
    always_comb begin
        mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            mask[i] = (i < int'(ptr_q));
        end
    end

    assign masked = req & mask;

    prio_pick_msb #(.SIZE(SIZE)) u_pick_masked (.vec(masked), .onehot(pick_m));
    prio_pick_msb #(.SIZE(SIZE)) u_pick_raw    (.vec(req),    .onehot(pick_r));

    assign winner   = (|masked) ? pick_m : pick_r;
    assign win_idx  = ID_W'(onehot_to_idx(MAX_SIZE'(winner)));
    assign rel_beat = ready & last;

`ifdef RR_LOCK_ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_CYC + 1);
    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    // Held at zero while idle, so every BUSY entry starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= (state_q == IDLE) ? '0 : hold_cnt + 1'b1;
            timeout_q <= (state_q == BUSY) && !rel_beat && hold_hit;
        end
    end

    assign hold_hit = (state_q == BUSY) && (hold_cnt == CW'(HOLD_CYC - 1));
    assign timeout  = timeout_q;
`else
    assign hold_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|req) state_d = BUSY;
            BUSY: if (rel_beat || hold_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Any release leaves ptr alone; a forced release thus keeps the owner lowest.
    always_comb begin
        gnt_d    = '0;
        gnt_id_d = '0;
        valid_d  = 1'b0;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = winner;
                    gnt_id_d = win_idx;
                    valid_d  = 1'b1;
                    ptr_d    = win_idx;
                end
            end
            BUSY: begin
                if (!(rel_beat || hold_hit)) begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                    valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed self-checking bench for rr_lock_arbiter
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       last;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.SIZE(4), .HOLD_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .last      (last),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic et);
        logic [7:0] obs, exp;
        obs = {gnt, gnt_id, gnt_valid, timeout};
        exp = {eg, eid, |eg, et};
        total++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                     tag, gnt, gnt_id, gnt_valid, timeout, eg, eid, |eg, et);
            $error("check %s", tag);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; ready = 1'b0; last = 1'b0;
        tick; chk("reset_idle", 4'b0000, 2'd0, 1'b0);
        req = 4'b1010;
        tick; chk("reset_with_req", 4'b0000, 2'd0, 1'b0);

        rst = 1'b0;
        tick; chk("first_grant_msb", 4'b1000, 2'd3, 1'b0);

        req = 4'b0010; ready = 1'b1; last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; chk($sformatf("lock_hold_%0d", i), 4'b1000, 2'd3, 1'b0);
        end
        last = 1'b1;
        tick; chk("lock_release", 4'b0000, 2'd0, 1'b0);
        ready = 1'b0; last = 1'b0;
        tick; chk("after_release_grant", 4'b0010, 2'd1, 1'b0);
        ready = 1'b1; last = 1'b1;
        tick; chk("release_2", 4'b0000, 2'd0, 1'b0);

        rst = 1'b1;
        tick; chk("reset_before_fair", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b1111; ready = 1'b1; last = 1'b1;
        tick; chk("fair_g3", 4'b1000, 2'd3, 1'b0);
        tick; chk("fair_idle0", 4'b0000, 2'd0, 1'b0);
        tick; chk("fair_g2", 4'b0100, 2'd2, 1'b0);
        tick; chk("fair_idle1", 4'b0000, 2'd0, 1'b0);
        tick; chk("fair_g1", 4'b0010, 2'd1, 1'b0);
        tick; chk("fair_idle2", 4'b0000, 2'd0, 1'b0);
        tick; chk("fair_g0", 4'b0001, 2'd0, 1'b0);
        tick; chk("fair_idle3", 4'b0000, 2'd0, 1'b0);
        tick; chk("fair_wrap_g3", 4'b1000, 2'd3, 1'b0);

        req = 4'b0100;
        tick; chk("bp_pre_release", 4'b0000, 2'd0, 1'b0);
        ready = 1'b0; last = 1'b1;
        tick; chk("bp_grant", 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick; chk($sformatf("bp_hold_%0d", i), 4'b0100, 2'd2, 1'b0);
        end
        ready = 1'b1;
        tick; chk("bp_release", 4'b0000, 2'd0, 1'b0);

        req = 4'b0010; ready = 1'b0; last = 1'b0;
        tick; chk("mid_busy_grant", 4'b0010, 2'd1, 1'b0);
        rst = 1'b1; req = 4'b0011;
        tick; chk("mid_busy_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick; chk("post_reset_grant", 4'b0010, 2'd1, 1'b0);

        req = 4'b0001; ready = 1'b1; last = 1'b1;
        tick; chk("to_release", 4'b0000, 2'd0, 1'b0);
        ready = 1'b0; last = 1'b0;
        tick; chk("to_grant", 4'b0001, 2'd0, 1'b0);
        req = 4'b1001; ready = 1'b1; last = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick; chk($sformatf("to_hold_%0d", i), 4'b0001, 2'd0, 1'b0);
        end
`ifdef RR_LOCK_ARB_HOLD_TIMEOUT_EN
        tick; chk("to_forced_release", 4'b0000, 2'd0, 1'b1);
        tick; chk("to_next_grant", 4'b1000, 2'd3, 1'b0);
`else
        for (int i = 0; i < 4; i++) begin
            tick; chk($sformatf("to_held_forever_%0d", i), 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
